alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have ports `clk`, `rst_n`, then the following, in this order:
- `clk`  input  1  single system clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req0_valid`  input  1  requester 0 has an operation pending.
- `req0_ready`  output  1  requester 0 operation accepted this cycle.
- `req0_a`  input  32  requester 0 operand a.
- `req0_b`  input  32  requester 0 operand b.
- `req0_f`  input  3  requester 0 function code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_f`  same widths and meaning for requester 1.
- `rsp_valid`  output  1  result available.
- `rsp_ready`  input  1  consumer accepts result.
- `rsp_y`  output  32  registered result.
- `rsp_zero`  output  1  registered flag, 1 when `rsp_y` == 0.
- `rsp_id`  output  1  index of the requester that owns the result.

Function
REQ-002 Function codes SHALL be:
- 000: a AND b.
- 001: a OR b.
- 010: a + b, mod 2^32.
- 110: a − b, mod 2^32.
- 111: signed a < b gives 1, else 0.
- 011, 100 and 101: result 0.
REQ-003 A single shared ALU datapath SHALL serve both requesters; at most one operation is in flight.
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-005 IDLE behaviour:
- `reqN_ready` is combinationally high only for the granted requester, and only when its valid is high.
- All readies are low in EXEC and RESP.
REQ-006 On an IDLE edge with a handshake (valid && ready):
- a, b, f and the requester id are captured into internal registers.
- The FSM moves to EXEC.
- With no handshake, the FSM stays in IDLE.
REQ-007 On the EXEC edge:
- The ALU output is computed from the captured operands.
- It is registered into `rsp_y`, and `rsp_zero` = (result == 0) is registered with it.
- `rsp_id` is loaded from the captured id.
- The FSM moves to RESP.
REQ-008 In RESP:
- `rsp_valid` is 1.
- `rsp_y`, `rsp_zero` and `rsp_id` hold stable until `rsp_valid` && `rsp_ready`.
- On that edge the FSM returns to IDLE.
REQ-009 Timing SHALL be:
- Latency from the accept edge to `rsp_valid` high is one cycle.
- Best-case throughput is one operation per 3 cycles, with `rsp_ready` held high.
REQ-010 Requests SHALL NOT be dropped: a requester holding valid low→high while the block is busy is served once the FSM returns to IDLE.
REQ-011 Request signals changing in EXEC or RESP SHALL NOT affect the in-flight operation.
REQ-012 `rsp_y`, `rsp_zero` and `rsp_id` are don't-care while `rsp_valid` is 0, but SHALL retain their last loaded values.

Reset
REQ-013 Asserting `rst_n` low SHALL immediately, without waiting for a clock edge:
- Force the FSM to IDLE.
- Force `rsp_valid`=0, `rsp_y`=0, `rsp_zero`=0, `rsp_id`=0.
- Zero the captured operand registers.
- Set the round-robin pointer to "last served = 1".
REQ-014 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is issued for it.
REQ-015 After `rst_n` rises, the first rising edge SHALL behave as an IDLE cycle.

Configuration
REQ-016 Macro `ALU_ARB_ROUND_ROBIN_EN` SHALL control arbitration:
- Defined:
  - When both valids are high in IDLE, the block grants the requester not served last.
  - When only one is valid, that one is granted.
  - The last-served pointer updates on every accepted handshake.
- Undefined:
  - Fixed priority: requester 0 always wins when both are valid.
  - The pointer logic is absent.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Single op: req0 a=5, b=3, f=010, `rsp_ready`=1 → `rsp_valid` one cycle after accept; `rsp_y`=8, `rsp_zero`=0, `rsp_id`=0.
- Subtract to zero and SLT: req1 a=7, b=7, f=110 → `rsp_y`=0, `rsp_zero`=1, `rsp_id`=1; then a=0xFFFFFFFF, b=1, f=111 → `rsp_y`=1.
- Contention: both valid continuously with 4 ops each.
  - With `ALU_ARB_ROUND_ROBIN_EN`: grant order 0,1,0,1,…
  - Without it: four req0 ops before any req1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` stays 1, `rsp_y` stable, both readies stay 0; release → return to IDLE next edge.
- Illegal code: f=101, a=0xFFFF, b=0xFFFF → `rsp_y`=0, `rsp_zero`=1.
- Reset mid-op: assert `rst_n`=0 during EXEC → `rsp_valid`=0 with no clock edge, no response after release; the next request is served normally, and requester 0 wins first under contention.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise requester 0 has fixed priority.
`timescale 1ns/1ps
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_f,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_f,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_zero,
  output logic        rsp_id
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  f_q;
  logic        id_q;
  logic [31:0] y_q;
  logic        zero_q, rid_q;
  logic        gnt_id;
  logic        hs;
  logic [31:0] alu_y;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Under contention the requester not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else                          gnt_id = ~req0_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_q <= 1'b1;
    else if (hs) last_q <= gnt_id;
  end
`else
  assign gnt_id = ~req0_valid;
`endif

  assign req0_ready = (state_q == StIdle) && req0_valid && !gnt_id;
  assign req1_ready = (state_q == StIdle) && req1_valid && gnt_id;
  assign hs         = req0_ready || req1_ready;

  always_comb begin
    alu_y = 32'h0;
    case (f_q)
      3'b000:  alu_y = a_q & b_q;
      3'b001:  alu_y = a_q | b_q;
      3'b010:  alu_y = a_q + b_q;
      3'b110:  alu_y = a_q - b_q;
      3'b111:  alu_y = {31'h0, $signed(a_q) < $signed(b_q)};
      default: alu_y = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (hs) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      f_q     <= 3'h0;
      id_q    <= 1'b0;
      y_q     <= 32'h0;
      zero_q  <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        a_q  <= gnt_id ? req1_a : req0_a;
        b_q  <= gnt_id ? req1_b : req0_b;
        f_q  <= gnt_id ? req1_f : req0_f;
        id_q <= gnt_id;
      end
      if (state_q == StExec) begin
        y_q    <= alu_y;
        zero_q <= (alu_y == 32'h0);
        rid_q  <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_y     = y_q;
  assign rsp_zero  = zero_q;
  assign rsp_id    = rid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter; contention expectations follow
// whether ALU_ARB_ROUND_ROBIN_EN is defined.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_f = '0, req1_f = '0;
  logic        rsp_valid, rsp_zero, rsp_id;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_y;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_f    (req0_f),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_f    (req1_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the DUT idle; leaves it idle again.
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] ey, input logic ez);
    logic got;
    got = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
    end
    #1;
    for (int i = 0; i < 10; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("accept", 32'(got), 32'h1);
    chk("other_ready", 32'(id ? req0_ready : req1_ready), 32'h0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) return;
    chk("exec_valid", 32'(rsp_valid), 32'h0);
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_zero", 32'(rsp_zero), 32'(ez));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    step();
    chk("ret_idle", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  cnt0, cnt1, k;
    logic order [8];

    vecs[0]  = '{1'b0, 32'd5,         32'd3,         3'b010, 32'd8,         1'b0};
    vecs[1]  = '{1'b1, 32'd7,         32'd7,         3'b110, 32'd0,         1'b1};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'd1,         3'b111, 32'd1,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 3'b101, 32'd0,         1'b1};
    vecs[4]  = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0};
    vecs[5]  = '{1'b1, 32'hF0F0_F0F0, 32'h0F0F_0000, 3'b001, 32'hFFFF_F0F0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         3'b010, 32'd0,         1'b1};
    vecs[7]  = '{1'b1, 32'd0,         32'd1,         3'b110, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{1'b0, 32'd1,         32'hFFFF_FFFF, 3'b111, 32'd0,         1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1,         1'b0};
    vecs[10] = '{1'b1, 32'd3,         32'd5,         3'b011, 32'd0,         1'b1};
    vecs[11] = '{1'b0, 32'd3,         32'd5,         3'b100, 32'd0,         1'b1};

    // Reset state
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_y", rsp_y, 32'h0);
    chk("rst_zero", 32'(rsp_zero), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].y, vecs[i].z);

    // Backpressure, plus a request raised while busy that must be served afterwards
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_f = 3'b010;
    #1;
    chk("bp_accept", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0; req0_a = 32'd999;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_f = 3'b010;
    #1;
    chk("bp_exec_ready1", 32'(req1_ready), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_y", rsp_y, 32'd30);
      chk("bp_ready0", 32'(req0_ready), 32'h0);
      chk("bp_ready1", 32'(req1_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle", 32'(rsp_valid), 32'h0);
    chk("pend_ready1", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    step();
    chk("pend_y", rsp_y, 32'd3);
    chk("pend_id", 32'(rsp_id), 32'h1);
    step();

    // Reset in EXEC: asynchronous clear, the op is dropped
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
    #1;
    chk("rst_op_accept", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'h0);
    chk("async_y", rsp_y, 32'h0);
    chk("async_id", 32'(rsp_id), 32'h0);
    step();
    step();
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'h0);
      step();
    end

    // Contention: both requesters hold valid for four ops each
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_f = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_f = 3'b001;
    #1;
    cnt0 = 0; cnt1 = 0; k = 0;
    for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
      if (req0_ready && req1_ready) chk("both_ready", 32'h1, 32'h0);
      if (req0_ready) begin
        order[k] = 1'b0; k++; cnt0++;
      end else if (req1_ready) begin
        order[k] = 1'b1; k++; cnt1++;
      end
      if (rsp_valid) chk("cont_y", rsp_y, rsp_id ? 32'd13 : 32'd5);
      step();
      if (cnt0 == 4) req0_valid = 1'b0;
      if (cnt1 == 4) req1_valid = 1'b0;
    end
    chk("cont_count", 32'(k), 32'd8);
    for (int i = 0; i < k; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      chk("grant_order", 32'(order[i]), 32'(i % 2));
`else
      chk("grant_order", 32'(order[i]), (i < 4) ? 32'h0 : 32'h1);
`endif
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
